jstk_xfer_sched: RTL and testbench
==================================

JSTK_XFER_SCHED -- requirements
Module: jstk_xfer_sched

Interface
REQ-001 Parameter GAP_CYCLES, default 2, CLK cycles held after SS falls and between bytes; legal range 1..255, and 0 behaves as 1.
REQ-002 Parameter POLL_PERIOD, default 3333, CLK cycles between automatic polls; used only with JSTK_POLL_EN.
REQ-003 CLK  input  1  single clock (66.67 kHz serial clock domain); all state changes on rising edge.
REQ-004 RST  input  1  reset, asynchronous, active-high.
REQ-005 START  input  1  request one 5-byte joystick read; level sampled in IDLE.
REQ-006 SPI_BUSY  input  1  busy flag from the SPI mode-0 byte engine.
REQ-007 SPI_DOUT  input  8  received byte from the SPI engine, valid once SPI_BUSY falls.
REQ-008 SND_REC  output  1  byte-transfer request to the SPI engine.
REQ-009 SS  output  1  slave select to PmodJSTK, active-low.
REQ-010 X_POS  output  10  last completed X reading.
REQ-011 Y_POS  output  10  last completed Y reading.
REQ-012 BTNS  output  3  last completed button state: {btn2, btn1, stick}.
REQ-013 DVALID  output  1  one-cycle pulse when X_POS/Y_POS/BTNS update.
REQ-014 BUSY  output  1  high from transaction launch through the DONE cycle inclusive.

Function
REQ-015 FSM states: IDLE, SSDLY, REQ, WAIT, CAPT, GAP, DONE.
REQ-016 IDLE -> SSDLY when the launch condition is true (START=1, or poll pending under JSTK_POLL_EN); SS goes low and BUSY goes high on that same edge, and byte index idx clears to 0.
REQ-017 SSDLY holds GAP_CYCLES cycles via a down-counter, then moves to REQ.
REQ-018 REQ drives SND_REC=1 and stays in REQ until SPI_BUSY=1 is sampled; then SND_REC drops to 0 on that edge and the FSM moves to WAIT.
REQ-019 WAIT stays in WAIT while SPI_BUSY=1; SPI_BUSY=0 moves it to CAPT.
REQ-020 CAPT writes SPI_DOUT into buf[idx]; if idx=4 the FSM moves to DONE, otherwise idx increments and the FSM moves to GAP.
REQ-021 GAP holds GAP_CYCLES cycles, then moves to REQ.
REQ-022 DONE drives SS=1, pulses DVALID for exactly one cycle, updates all outputs atomically, then moves to IDLE; BUSY=0 in the following IDLE cycle.
REQ-023 Byte mapping: X_POS={buf[1][1:0],buf[0]}; Y_POS={buf[3][1:0],buf[2]}; BTNS=buf[4][2:0]; unused high bits are discarded.
REQ-024 START asserted outside IDLE is ignored and is not queued.
REQ-025 START held high continuously relaunches from IDLE after each DONE, so back-to-back transactions are separated by exactly one IDLE cycle.
REQ-026 X_POS, Y_POS and BTNS never change except in DONE; a partial transaction never alters them.
REQ-027 SS stays low continuously from launch until DONE, including all GAP states.

Reset
REQ-028 RST=1 forces, asynchronously: state IDLE, SS=1, SND_REC=0, BUSY=0, DVALID=0, X_POS=0, Y_POS=0, BTNS=0, idx=0, counters=0, buffer=0, poll pending=0.
REQ-029 RST asserted mid-transaction aborts it immediately with no DVALID pulse; the first launch after RST deasserts starts from byte 0.

Configuration
REQ-030 With macro JSTK_POLL_EN defined: a free-running down-counter reloads to POLL_PERIOD-1 on reaching 0 and sets a pending flag on that edge; the pending flag is a launch condition in IDLE and clears on launch.
REQ-031 With JSTK_POLL_EN defined: a poll expiring while a transaction is in progress stays pending and launches at the next IDLE; START and pending together produce exactly one transaction and both are consumed.
REQ-032 Without JSTK_POLL_EN: no poll counter is implemented, POLL_PERIOD is ignored, and only START launches transactions.

Verification
REQ-033 SPI model returns bytes 0x34,0x02,0xCD,0x01,0x05; pulse START -> one DVALID; X_POS=0x234, Y_POS=0x1CD, BTNS=3'b101.
REQ-034 GAP_CYCLES=3; pulse START -> SS low to first SND_REC rise = 3 cycles; each CAPT to next SND_REC = 3 cycles; exactly 5 SND_REC handshakes.
REQ-035 SPI model delays SPI_BUSY by 4 cycles -> SND_REC remains high 4 cycles and drops on the edge where SPI_BUSY=1 is sampled.
REQ-036 RST asserted during byte 2 -> SS=1 and BUSY=0 immediately, outputs hold 0, no DVALID; a following START completes a normal transaction.
REQ-037 START pulsed during WAIT -> ignored; exactly one DVALID is produced.
REQ-038 JSTK_POLL_EN defined, POLL_PERIOD=200, START held 0 -> DVALID pulses with period 200 cycles; with the macro undefined, no DVALID ever occurs.

Source files
------------

// File: rtl/jstk_xfer_sched.sv
// PmodJSTK 5-byte read sequencer in front of an SPI mode-0 byte engine.
// Optional `JSTK_POLL_EN adds a free-running auto-poll timer of POLL_PERIOD cycles.
module jstk_xfer_sched #(
    parameter int GAP_CYCLES  = 2,
    parameter int POLL_PERIOD = 3333
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       START,
    input  logic       SPI_BUSY,
    input  logic [7:0] SPI_DOUT,
    output logic       SND_REC,
    output logic       SS,
    output logic [9:0] X_POS,
    output logic [9:0] Y_POS,
    output logic [2:0] BTNS,
    output logic       DVALID,
    output logic       BUSY
);
    localparam int         GAP_EFF  = (GAP_CYCLES < 1) ? 1 : GAP_CYCLES;
    localparam logic [7:0] GAP_LOAD = 8'(GAP_EFF - 1);

    typedef enum logic [2:0] {
        IDLE, SSDLY, REQ, WAIT, CAPT, GAP, DONE
    } state_t;

    state_t      state, state_nxt;
    logic [2:0]  idx, idx_nxt;
    logic [7:0]  cnt, cnt_nxt;
    logic        cap_en;
    logic        launch;
    logic        poll_pend;
    logic [7:0]  rx_buf [0:4];

`ifdef JSTK_POLL_EN
    logic [31:0] poll_cnt;

    // An expiry on the same edge as a launch re-arms the flag so it is never lost.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            poll_cnt  <= '0;
            poll_pend <= 1'b0;
        end else if (poll_cnt == 32'd0) begin
            poll_cnt  <= 32'(POLL_PERIOD - 1);
            poll_pend <= 1'b1;
        end else begin
            poll_cnt <= poll_cnt - 32'd1;
            if (launch)
                poll_pend <= 1'b0;
        end
    end
`else
    logic unused_poll;
    assign poll_pend   = 1'b0;
    assign unused_poll = ^32'(POLL_PERIOD);
`endif

    assign launch = (state == IDLE) && (START || poll_pend);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
            idx   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        cnt_nxt   = cnt;
        cap_en    = 1'b0;
        SND_REC   = (state == REQ);
        SS        = (state == IDLE) || (state == DONE);
        BUSY      = (state != IDLE);
        DVALID    = (state == DONE);
        case (state)
            IDLE: begin
                if (launch) begin
                    state_nxt = SSDLY;
                    idx_nxt   = '0;
                    cnt_nxt   = GAP_LOAD;
                end
            end
            SSDLY, GAP: begin
                if (cnt == 8'd0)
                    state_nxt = REQ;
                else
                    cnt_nxt = cnt - 8'd1;
            end
            REQ: begin
                if (SPI_BUSY)
                    state_nxt = WAIT;
            end
            WAIT: begin
                if (!SPI_BUSY)
                    state_nxt = CAPT;
            end
            CAPT: begin
                cap_en = 1'b1;
                if (idx == 3'd4) begin
                    state_nxt = DONE;
                end else begin
                    idx_nxt   = idx + 3'd1;
                    cnt_nxt   = GAP_LOAD;
                    state_nxt = GAP;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Results load on the CAPT->DONE edge, straight from SPI_DOUT for the last
    // byte, so they are already valid during the DVALID cycle.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < 5; i++)
                rx_buf[i] <= '0;
            X_POS <= '0;
            Y_POS <= '0;
            BTNS  <= '0;
        end else if (cap_en) begin
            rx_buf[idx] <= SPI_DOUT;
            if (idx == 3'd4) begin
                X_POS <= {rx_buf[1][1:0], rx_buf[0]};
                Y_POS <= {rx_buf[3][1:0], rx_buf[2]};
                BTNS  <= SPI_DOUT[2:0];
            end
        end
    end

    logic unused_bits;
    assign unused_bits = ^{rx_buf[1][7:2], rx_buf[3][7:2], rx_buf[4]};

endmodule

// File: tb/tb_jstk_xfer_sched.sv
// Bench for jstk_xfer_sched: SPI byte-engine model, timing monitor, vector table and random reads.
module tb_jstk_xfer_sched;
    localparam int GAP = 3;
    localparam int PER = 200;

    logic       CLK = 1'b0;
    logic       RST;
    logic       START = 1'b0;
    logic       SPI_BUSY = 1'b0;
    logic [7:0] SPI_DOUT = 8'h00;
    logic       SND_REC, SS, DVALID, BUSY;
    logic [9:0] X_POS, Y_POS;
    logic [2:0] BTNS;

    int checks = 0;
    int errors = 0;

    jstk_xfer_sched #(.GAP_CYCLES(GAP), .POLL_PERIOD(PER)) dut (
        .CLK(CLK), .RST(RST), .START(START), .SPI_BUSY(SPI_BUSY), .SPI_DOUT(SPI_DOUT),
        .SND_REC(SND_REC), .SS(SS), .X_POS(X_POS), .Y_POS(Y_POS), .BTNS(BTNS),
        .DVALID(DVALID), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: byte-to-field mapping done with plain arithmetic.
    task automatic ref_model(input logic [39:0] b, output logic [9:0] x, output logic [9:0] y,
                             output logic [2:0] k);
        int b0, b1, b2, b3, b4;
        b0 = int'(b[7:0]);   b1 = int'(b[15:8]);  b2 = int'(b[23:16]);
        b3 = int'(b[31:24]); b4 = int'(b[39:32]);
        x = 10'((b1 % 4) * 256 + b0);
        y = 10'((b3 % 4) * 256 + b2);
        k = 3'(b4 % 8);
    endtask

    // SPI engine model plus protocol monitor, one process so ordering is fixed.
    logic [7:0] spi_q [$];
    int   spi_dly = 1, spi_len = 1;
    int   cyc = 0, dv_count = 0, snd_in_xfer = 0;
    int   ss_fall_cyc = 0, snd_rise_cyc = 0, busy_fall_cyc = 0;
    int   m_cnt = 0, m_left = 0;
    bit   m_busy = 1'b0;
    logic prev_ss = 1'b1, prev_snd = 1'b0;
    logic [22:0] prev_out = '0;

    always @(negedge CLK) begin
        cyc++;
        if (RST) begin
            m_busy = 1'b0; m_cnt = 0; SPI_BUSY = 1'b0; snd_in_xfer = 0;
            spi_q.delete();
        end else begin
            if (prev_ss && !SS) begin
                ss_fall_cyc = cyc;
                snd_in_xfer = 0;
            end
            if (!prev_snd && SND_REC) begin
                if (snd_in_xfer == 0)
                    chk("ss_fall_to_snd_rec", 32'(cyc - ss_fall_cyc), 32'(GAP));
                else // one CAPT cycle, then GAP cycles, then REQ
                    chk("busy_fall_to_snd_rec", 32'(cyc - busy_fall_cyc), 32'(GAP + 2));
                snd_in_xfer++;
                snd_rise_cyc = cyc;
            end
            if (prev_snd && !SND_REC)
                chk("snd_rec_high_cycles", 32'(cyc - snd_rise_cyc), 32'(spi_dly));
            if (BUSY && !DVALID)
                chk("ss_low_in_xfer", 32'(SS), 32'(0));
            if (DVALID) begin
                dv_count++;
                chk("handshakes", 32'(snd_in_xfer), 32'(5));
            end
            if ({X_POS, Y_POS, BTNS} !== prev_out)
                chk("outputs_change_only_with_dvalid", 32'(DVALID), 32'(1));
            if (m_busy) begin
                m_left--;
                if (m_left == 0) begin
                    m_busy = 1'b0;
                    SPI_BUSY = 1'b0;
                    SPI_DOUT = (spi_q.size() > 0) ? spi_q.pop_front() : 8'h00;
                    busy_fall_cyc = cyc;
                end
            end else if (SND_REC) begin
                m_cnt++;
                if (m_cnt >= spi_dly) begin
                    m_cnt = 0; m_busy = 1'b1; m_left = spi_len; SPI_BUSY = 1'b1;
                end
            end
        end
        prev_ss  = SS;
        prev_snd = SND_REC;
        prev_out = {X_POS, Y_POS, BTNS};
    end

    task automatic push_bytes(input logic [39:0] b);
        for (int i = 0; i < 5; i++)
            spi_q.push_back(b[8*i +: 8]);
    endtask

    task automatic wait_dv(input string tag);
        int i;
        for (i = 0; i < 1000; i++) begin
            @(negedge CLK);
            if (DVALID) break;
        end
        if (i == 1000) begin
            checks++; errors++;
            $display("FAIL %s: no DVALID within 1000 cycles", tag);
        end
    endtask

    task automatic check_out(input string tag, input logic [9:0] ex, input logic [9:0] ey,
                             input logic [2:0] eb);
        chk({tag, "_x"}, 32'(X_POS), 32'(ex));
        chk({tag, "_y"}, 32'(Y_POS), 32'(ey));
        chk({tag, "_btns"}, 32'(BTNS), 32'(eb));
    endtask

    task automatic do_xfer(input string tag, input logic [39:0] b, input int dly, input int len,
                           input logic [9:0] ex, input logic [9:0] ey, input logic [2:0] eb);
        int n;
        push_bytes(b);
        spi_dly = dly; spi_len = len;
        n = dv_count;
        @(negedge CLK); START = 1'b1;
        @(negedge CLK); START = 1'b0;
        wait_dv(tag);
        check_out(tag, ex, ey, eb);
        @(negedge CLK); #1;
        chk({tag, "_busy_after"}, 32'(BUSY), 32'(0));
        chk({tag, "_dv_count"}, 32'(dv_count), 32'(n + 1));
    endtask

    typedef struct {
        logic [39:0] bytes;
        int          dly;
        int          len;
        logic [9:0]  x;
        logic [9:0]  y;
        logic [2:0]  b;
    } vec_t;

    vec_t tbl [4];

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [39:0] rb;
        logic [9:0]  ex, ey;
        logic [2:0]  eb;
        int i, n, t;

        // {b4,b3,b2,b1,b0}, SPI delay, SPI busy length, expected X, Y, BTNS
        tbl[0] = '{40'h05_01_CD_02_34, 1, 1, 10'h234, 10'h1CD, 3'b101};
        tbl[1] = '{40'hFF_FF_FF_FF_FF, 4, 2, 10'h3FF, 10'h3FF, 3'b111};
        tbl[2] = '{40'hF8_FC_00_FD_00, 2, 3, 10'h100, 10'h000, 3'b000};
        tbl[3] = '{40'h02_02_7F_01_80, 3, 1, 10'h180, 10'h27F, 3'b010};

        RST = 1'b1;
        repeat (3) @(negedge CLK);
        #1;
        chk("rst_ss", 32'(SS), 32'(1));
        chk("rst_busy", 32'(BUSY), 32'(0));
        chk("rst_snd_rec", 32'(SND_REC), 32'(0));
        chk("rst_dvalid", 32'(DVALID), 32'(0));
        chk("rst_x", 32'(X_POS), 32'(0));
        chk("rst_y", 32'(Y_POS), 32'(0));
        chk("rst_btns", 32'(BTNS), 32'(0));
        @(negedge CLK); #2 RST = 1'b0;

`ifdef JSTK_POLL_EN
        push_bytes(tbl[0].bytes);
        wait_dv("poll_first");
        check_out("poll_first", tbl[0].x, tbl[0].y, tbl[0].b);
        #1 t = cyc;
        for (int k = 0; k < 3; k++) begin
            wait_dv("poll_next");
            #1;
            chk("poll_period", 32'(cyc - t), 32'(PER));
            t = cyc;
        end
`else
        // Abort during byte 2 (third request, engine busy)
        push_bytes(40'h11_22_33_44_55);
        spi_dly = 1; spi_len = 2;
        @(negedge CLK); START = 1'b1;
        @(negedge CLK); START = 1'b0;
        for (i = 0; i < 300; i++) begin
            @(negedge CLK); #1;
            if (snd_in_xfer == 3 && SPI_BUSY) break;
        end
        if (i == 300) begin
            checks++; errors++;
            $display("FAIL abort_reach_byte2: byte 2 never started");
        end
        #2 RST = 1'b1;
        #1;
        chk("abort_ss", 32'(SS), 32'(1));
        chk("abort_busy", 32'(BUSY), 32'(0));
        chk("abort_snd_rec", 32'(SND_REC), 32'(0));
        chk("abort_out", 32'({X_POS, Y_POS, BTNS}), 32'(0));
        @(negedge CLK); #2 RST = 1'b0;
        repeat (5) @(negedge CLK);
        #1 chk("abort_no_dvalid", 32'(dv_count), 32'(0));

        for (int k = 0; k < 4; k++)
            do_xfer($sformatf("vec%0d", k), tbl[k].bytes, tbl[k].dly, tbl[k].len,
                    tbl[k].x, tbl[k].y, tbl[k].b);

        for (int k = 0; k < 8; k++) begin
            rb = {8'($urandom), $urandom};
            ref_model(rb, ex, ey, eb);
            do_xfer($sformatf("rand%0d", k), rb, int'($urandom_range(1, 4)),
                    int'($urandom_range(1, 3)), ex, ey, eb);
        end

        // START pulsed while the engine is busy is dropped
        push_bytes(tbl[3].bytes);
        spi_dly = 1; spi_len = 4;
        n = dv_count;
        @(negedge CLK); START = 1'b1;
        @(negedge CLK); START = 1'b0;
        for (i = 0; i < 300; i++) begin
            @(negedge CLK); #1;
            if (SPI_BUSY) break;
        end
        chk("wait_start_in_xfer", 32'(BUSY), 32'(1));
        START = 1'b1;
        @(negedge CLK); START = 1'b0;
        wait_dv("wait_start");
        check_out("wait_start", tbl[3].x, tbl[3].y, tbl[3].b);
        repeat (80) @(negedge CLK);
        #1 chk("wait_start_one_dvalid", 32'(dv_count), 32'(n + 1));

        // START held: back-to-back with a single IDLE cycle between
        push_bytes(tbl[0].bytes);
        push_bytes(tbl[1].bytes);
        spi_dly = 2; spi_len = 1;
        n = dv_count;
        @(negedge CLK); START = 1'b1;
        wait_dv("b2b_first");
        check_out("b2b_first", tbl[0].x, tbl[0].y, tbl[0].b);
        @(negedge CLK); #1 chk("b2b_idle_gap", 32'(BUSY), 32'(0));
        @(negedge CLK); #1 chk("b2b_relaunch", 32'(BUSY), 32'(1));
        wait_dv("b2b_second");
        check_out("b2b_second", tbl[1].x, tbl[1].y, tbl[1].b);
        @(negedge CLK); START = 1'b0;
        repeat (20) @(negedge CLK);
        #1;
        chk("b2b_dv_count", 32'(dv_count), 32'(n + 2));
        chk("b2b_stopped", 32'(BUSY), 32'(0));

        // No auto-poll in this build
        n = dv_count;
        repeat (400) @(negedge CLK);
        #1 chk("no_poll_dvalid", 32'(dv_count), 32'(n));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
